// File: rtl/mem_stage_bus_if.sv
// MEM-stage load/store bus between the EX/MEM register and mem_stage_bus.
// Latency: ReadData is combinational, valid in the same cycle as MemRd.
// Backpressure: none; every access completes in a single cycle.
// Signals:
//   MemRd     load strobe                 (master -> slave)
//   MemWr     store strobe                (master -> slave)
//   Addr      byte address, word aligned  (master -> slave)
//   WriteData store data                  (master -> slave)
//   ReadData  load data, 0 when idle      (slave -> master)
interface mem_stage_bus_if;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemRd,
    output MemWr,
    output Addr,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemRd,
    input  MemWr,
    input  Addr,
    input  WriteData,
    output ReadData
  );
endinterface

// File: rtl/mem_stage_bus.sv
// MEM-stage data RAM plus memory-mapped timer, LEDs, switches, 7-seg and tick counter.
// Latency: loads are combinational (zero cycles); stores commit at the next clk edge.
// Backpressure: none; the bus is always ready, one access per cycle.
// Ports:
//   clk, reset  pipeline clock, asynchronous active-low reset
//   bus         slave side of mem_stage_bus_if (MemRd/MemWr/Addr/WriteData/ReadData)
//   switch      board switches, read directly at 0x40000010
//   led, digi   LED and 7-seg registers ([11:8] anode select, [7:0] segments)
//   irqout      timer interrupt request (irq enable AND irq status)
module mem_stage_bus #(
  parameter int RAM_WORDS = 256,
  parameter int RAM_AW    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_stage_bus_if.slave        bus,
  input  logic [7:0]            switch,
  output logic [7:0]            led,
  output logic [11:0]           digi,
  output logic                  irqout
);

  // Peripheral word addresses (byte address >> 2).
  localparam logic [29:0] WA_TH   = 30'h1000_0000;
  localparam logic [29:0] WA_TL   = 30'h1000_0001;
  localparam logic [29:0] WA_TCON = 30'h1000_0002;
  localparam logic [29:0] WA_LED  = 30'h1000_0003;
  localparam logic [29:0] WA_SW   = 30'h1000_0004;
  localparam logic [29:0] WA_DIGI = 30'h1000_0005;
  localparam logic [29:0] WA_TICK = 30'h1000_0006;

  // TCON bit positions.
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_SW,
    SEL_DIGI,
    SEL_TICK
  } sel_e;

  sel_e              sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic [31:0]       ram [RAM_WORDS];

  logic              wr_th;
  logic              wr_tl;
  logic              wr_tcon;
  logic              wr_led;
  logic              wr_digi;

  logic [31:0]       th_q,      th_d;
  logic [31:0]       tl_q,      tl_d;
  logic [2:0]        tcon_q,    tcon_d;
  logic [7:0]        led_q,     led_d;
  logic [11:0]       digi_q,    digi_d;
  logic [31:0]       systick_q, systick_d;

  logic [31:0]       read_dat;

  // Byte-lane bits are never used; every access is a whole word.
  logic              unused_addr_lsb;
  assign unused_addr_lsb = ^bus.Addr[1:0];

  // ------------------------------------------------------------------
  // Address decode. Everything below 0x40000000 is RAM; the upper bits
  // beyond the RAM index are dropped, so the RAM image repeats.
  // ------------------------------------------------------------------
  always_comb begin
    sel = SEL_NONE;
    if (bus.Addr[31:30] == 2'b00) begin
      sel = SEL_RAM;
    end else begin
      case (bus.Addr[31:2])
        WA_TH:   sel = SEL_TH;
        WA_TL:   sel = SEL_TL;
        WA_TCON: sel = SEL_TCON;
        WA_LED:  sel = SEL_LED;
        WA_SW:   sel = SEL_SW;
        WA_DIGI: sel = SEL_DIGI;
        WA_TICK: sel = SEL_TICK;
        default: sel = SEL_NONE;
      endcase
    end
  end

  assign ram_idx = bus.Addr[RAM_AW+1:2];

  assign wr_th   = bus.MemWr && (sel == SEL_TH);
  assign wr_tl   = bus.MemWr && (sel == SEL_TL);
  assign wr_tcon = bus.MemWr && (sel == SEL_TCON);
  assign wr_led  = bus.MemWr && (sel == SEL_LED);
  assign wr_digi = bus.MemWr && (sel == SEL_DIGI);

  // ------------------------------------------------------------------
  // Data RAM: no reset on the array. The write strobe is qualified by
  // reset so a store sitting on the bus while reset is held is dropped.
  // ------------------------------------------------------------------
  assign ram_we = bus.MemWr && (sel == SEL_RAM) && reset;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= bus.WriteData;
    end
  end

  // ------------------------------------------------------------------
  // Timer and register next-state. The autonomous timer update is
  // computed first and CPU writes are layered on top, so a CPU write to
  // TL or TCON overrides the increment/reload and the status set in the
  // same cycle. Reload always takes the pre-edge TH.
  // ------------------------------------------------------------------
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;

    if (tcon_q[TCON_EN]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[TCON_IE]) begin
          tcon_d[TCON_ST] = 1'b1;
        end
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    if (wr_th) begin
      th_d = bus.WriteData;
    end
    if (wr_tl) begin
      tl_d = bus.WriteData;
    end
    if (wr_tcon) begin
      tcon_d = bus.WriteData[2:0];
    end
    if (wr_led) begin
      led_d = bus.WriteData[7:0];
    end
    if (wr_digi) begin
      digi_d = bus.WriteData[11:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
    end
  end

  // ------------------------------------------------------------------
  // Load path: combinational, pre-edge register values, narrow
  // registers zero-extended, zero whenever no load is requested.
  // ------------------------------------------------------------------
  always_comb begin
    read_dat = '0;
    if (bus.MemRd) begin
      case (sel)
        SEL_RAM:  read_dat = ram[ram_idx];
        SEL_TH:   read_dat = th_q;
        SEL_TL:   read_dat = tl_q;
        SEL_TCON: read_dat = {29'd0, tcon_q};
        SEL_LED:  read_dat = {24'd0, led_q};
        SEL_SW:   read_dat = {24'd0, switch};
        SEL_DIGI: read_dat = {20'd0, digi_q};
        SEL_TICK: read_dat = systick_q;
        default:  read_dat = '0;
      endcase
    end
  end

  assign bus.ReadData = read_dat;

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[TCON_IE] & tcon_q[TCON_ST];

endmodule

// File: tb/tb_mem_stage_bus.sv
`timescale 1ns/1ps
module tb_mem_stage_bus;

  localparam int          RAM_WORDS = 256;
  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LED     = 32'h4000_000C;
  localparam logic [31:0] A_SW      = 32'h4000_0010;
  localparam logic [31:0] A_DIGI    = 32'h4000_0014;
  localparam logic [31:0] A_TICK    = 32'h4000_0018;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  switch_v;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  int checks = 0;
  int errors = 0;

  mem_stage_bus_if bus_if ();

  mem_stage_bus #(.RAM_WORDS(RAM_WORDS), .RAM_AW(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .switch (switch_v),
    .led    (led),
    .digi   (digi),
    .irqout (irqout)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_th, m_tl, m_tick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [11:0] m_digi;
  logic [31:0] m_ram [RAM_WORDS];

  function automatic logic [7:0] ram_slot(input logic [31:0] a);
    return 8'((a >> 2) % RAM_WORDS);
  endfunction

  function automatic void model_reset();
    m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_tick = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [7:0] sw);
    logic [31:0] w;
    w = a & ~32'h3;
    if (a < 32'h4000_0000) return m_ram[ram_slot(a)];
    case (w)
      A_TH:    return m_th;
      A_TL:    return m_tl;
      A_TCON:  return {29'd0, m_tcon};
      A_LED:   return {24'd0, m_led};
      A_SW:    return {24'd0, sw};
      A_DIGI:  return {20'd0, m_digi};
      A_TICK:  return m_tick;
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge: timer behaviour first, then the CPU write overrides.
  function automatic void model_edge(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] nth, ntl, w;
    logic [2:0]  ntcon;
    nth = m_th; ntl = m_tl; ntcon = m_tcon; w = a & ~32'h3;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        ntl = m_th;
        if (m_tcon[1]) ntcon[2] = 1'b1;
      end else begin
        ntl = m_tl + 32'd1;
      end
    end
    if (wr) begin
      if (a < 32'h4000_0000) m_ram[ram_slot(a)] = d;
      else case (w)
        A_TH:    nth = d;
        A_TL:    ntl = d;
        A_TCON:  ntcon = d[2:0];
        A_LED:   m_led = d[7:0];
        A_DIGI:  m_digi = d[11:0];
        default: ;
      endcase
    end
    m_th = nth; m_tl = ntl; m_tcon = ntcon; m_tick = m_tick + 32'd1;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus_if.MemRd = rd; bus_if.MemWr = wr; bus_if.Addr = a; bus_if.WriteData = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 32'd0);
    #1;
    check(name, bus_if.ReadData, exp);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // One random-phase cycle checked against the model.
  task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] sw);
    drive(rd, wr, a, d);
    switch_v = sw;
    #1;
    check("rnd_rdata", bus_if.ReadData, rd ? model_read(a, sw) : 32'd0);
    check("rnd_led",   {24'd0, led},     {24'd0, m_led});
    check("rnd_digi",  {20'd0, digi},    {20'd0, m_digi});
    check("rnd_irq",   {31'd0, irqout},  {31'd0, m_tcon[1] & m_tcon[2]});
    step();
    model_edge(wr, a, d);
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [7:0]  sw;
    logic [31:0] exp_rd;
    logic [7:0]  exp_led;
    logic [11:0] exp_digi;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            rd    wr    addr            wdata          sw     exp_rd         led    digi
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 8'h00, 32'h0000_0000, 8'h00, 12'h000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         8'h00, 32'hDEAD_BEEF, 8'h00, 12'h000};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0410, 32'h0,         8'h00, 32'hDEAD_BEEF, 8'h00, 12'h000};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         8'h00, 32'hDEAD_BEEF, 8'h00, 12'h000};
    vecs[4]  = '{1'b0, 1'b1, 32'h4000_000C, 32'h0000_01A5, 8'h00, 32'h0000_0000, 8'hA5, 12'h000};
    vecs[5]  = '{1'b1, 1'b0, 32'h4000_000C, 32'h0,         8'h00, 32'h0000_00A5, 8'hA5, 12'h000};
    vecs[6]  = '{1'b1, 1'b0, 32'h4000_0010, 32'h0,         8'h3C, 32'h0000_003C, 8'hA5, 12'h000};
    vecs[7]  = '{1'b0, 1'b1, 32'h4000_0010, 32'h0000_00FF, 8'h3C, 32'h0000_0000, 8'hA5, 12'h000};
    vecs[8]  = '{1'b1, 1'b0, 32'h4000_0011, 32'h0,         8'hC3, 32'h0000_00C3, 8'hA5, 12'h000};
    vecs[9]  = '{1'b1, 1'b0, 32'h4000_0020, 32'h0,         8'h00, 32'h0000_0000, 8'hA5, 12'h000};
    vecs[10] = '{1'b0, 1'b1, 32'h4000_0014, 32'hFFFF_F123, 8'h00, 32'h0000_0000, 8'hA5, 12'h123};
    vecs[11] = '{1'b1, 1'b0, 32'h4000_0016, 32'h0,         8'h00, 32'h0000_0123, 8'hA5, 12'h123};
    vecs[12] = '{1'b1, 1'b1, 32'h4000_000C, 32'h0000_005A, 8'h00, 32'h0000_00A5, 8'h5A, 12'h123};
    vecs[13] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         8'h00, 32'h0000_0000, 8'h5A, 12'h123};
    vecs[14] = '{1'b1, 1'b0, 32'hC000_0000, 32'h0,         8'h00, 32'h0000_0000, 8'h5A, 12'h123};
    vecs[15] = '{1'b0, 1'b1, 32'hC000_000C, 32'h0000_0033, 8'h00, 32'h0000_0000, 8'h5A, 12'h123};

    drive(1'b0, 1'b0, 32'd0, 32'd0);
    switch_v = 8'h00;

    // ---- reset, then idle tick count ----
    #2 reset = 1'b0;
    #1;
    check("rst_led",  {24'd0, led},    32'd0);
    check("rst_digi", {20'd0, digi},   32'd0);
    check("rst_irq",  {31'd0, irqout}, 32'd0);
    rd_chk("rst_tl",   A_TL,   32'd0);
    rd_chk("rst_tcon", A_TCON, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rd_chk("systick_10", A_TICK, 32'd10);

    // ---- table-driven RAM/peripheral vectors ----
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
      switch_v = vecs[i].sw;
      #1;
      check($sformatf("vec%0d_rdata", i), bus_if.ReadData, vecs[i].exp_rd);
      step();
      check($sformatf("vec%0d_led", i),  {24'd0, led},  {24'd0, vecs[i].exp_led});
      check($sformatf("vec%0d_digi", i), {20'd0, digi}, {20'd0, vecs[i].exp_digi});
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    switch_v = 8'h00;

    // ---- timer reload and irq ----
    bus_wr(A_TH, 32'hFFFF_FFFD);
    bus_wr(A_TL, 32'hFFFF_FFFE);
    bus_wr(A_TCON, 32'd3);
    step();
    rd_chk("tmr_tl_ff", A_TL, 32'hFFFF_FFFF);
    step();
    rd_chk("tmr_tl_reload", A_TL, 32'hFFFF_FFFD);
    check("tmr_irq_set", {31'd0, irqout}, 32'd1);
    bus_wr(A_TCON, 32'd3);
    check("tmr_irq_clr", {31'd0, irqout}, 32'd0);
    rd_chk("tmr_still_counting", A_TL, 32'hFFFF_FFFE);
    step();
    rd_chk("tmr_tl_ff2", A_TL, 32'hFFFF_FFFF);
    // overflow cycle: TL write wins, status still sets
    bus_wr(A_TL, 32'd5);
    rd_chk("col_tl_wr_wins", A_TL, 32'd5);
    rd_chk("col_status_set", A_TCON, 32'd7);
    check("col_irq_set", {31'd0, irqout}, 32'd1);
    bus_wr(A_TCON, 32'd3);
    rd_chk("col_tl_counts", A_TL, 32'd6);
    bus_wr(A_TL, 32'hFFFF_FFFE);
    step();
    rd_chk("col_tl_ff", A_TL, 32'hFFFF_FFFF);
    // overflow cycle: TCON write wins over the status set
    bus_wr(A_TCON, 32'd3);
    check("col_tcon_irq", {31'd0, irqout}, 32'd0);
    rd_chk("col_tcon_status", A_TCON, 32'd3);
    rd_chk("col_tcon_reload", A_TL, 32'hFFFF_FFFD);
    step();
    step();
    // TH write in reload cycle: old TH reloads now, new TH next time
    bus_wr(A_TH, 32'h0000_0100);
    rd_chk("th_old_reload", A_TL, 32'hFFFF_FFFD);
    check("th_irq", {31'd0, irqout}, 32'd1);
    step();
    step();
    step();
    rd_chk("th_new_reload", A_TL, 32'h0000_0100);

    // ---- async reset mid-count ----
    bus_wr(A_LED, 32'h77);
    bus_wr(A_TL, 32'h1234);
    rd_chk("ar_pre_tl", A_TL, 32'h1234);
    check("ar_pre_irq", {31'd0, irqout}, 32'd1);
    #2 reset = 1'b0;
    rd_chk("ar_tl", A_TL, 32'd0);
    rd_chk("ar_tcon", A_TCON, 32'd0);
    check("ar_irq",  {31'd0, irqout}, 32'd0);
    check("ar_led",  {24'd0, led},    32'd0);
    check("ar_digi", {20'd0, digi},   32'd0);
    // store during reset is dropped; RAM contents survive reset
    drive(1'b0, 1'b1, 32'h10, 32'h1111_1111);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    #2 reset = 1'b1;
    step();
    rd_chk("ar_store_lost", 32'h10, 32'hDEAD_BEEF);

    // ---- randomized traffic against the model ----
    apply_reset();
    model_reset();
    step();
    model_edge(1'b0, 32'd0, 32'd0);
    for (int i = 0; i < RAM_WORDS; i++) begin
      cyc(1'b0, 1'b1, 32'(i) * 4, $urandom, 8'($urandom));
    end
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d, r;
      logic        rd, wr;
      int          k;
      k = $urandom_range(0, 99);
      r = $urandom;
      if (k < 35)      a = r & 32'h3FFF_FFFF;
      else if (k < 95) a = A_TH + 32'($urandom_range(0, 9)) * 4 + (r & 32'h3);
      else             a = r | 32'h8000_0000;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | (r & 32'hF);
      rd = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 2) == 0);
      cyc(rd, wr, a, d, 8'($urandom));
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
